packet_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI-stream packet sink between INPUTS packet sources, typically the outputs of several packet FIFOs (e.g. per-channel read-response or command queues).
- Grants one source for a whole packet, up to and including the beat with tlast, then re-arbitrates.
- Never interleaves packets.
- Reports the active grant and counts completed packets per source for debug.

---
 rtl/packet_arbiter.sv | 135 +++++++++++++
 tb/tb_packet_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_arbiter.sv
// Round-robin packet arbiter: shares one AXI-stream sink between INPUTS sources,
// holding each grant from the first beat through the tlast beat.
module packet_arbiter #(
   parameter int WIDTH  = 8,
   parameter int INPUTS = 2,   // 2..4, grant index is 2 bits wide
   parameter int CBITS  = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [INPUTS-1:0]         s_tvalid,
   output logic [INPUTS-1:0]         s_tready,
   input  logic [INPUTS-1:0]         s_tlast,
   input  logic [INPUTS*WIDTH-1:0]   s_tdata,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      m_tlast,
   output logic [WIDTH-1:0]          m_tdata,
   output logic                      busy_o,
   output logic [1:0]                grant_o,
   output logic [INPUTS*CBITS-1:0]   count_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [1:0]         r_grant;
   logic [1:0]         w_grant_next;
   logic [1:0]         r_last;
   logic [1:0]         w_last_next;
   logic               w_any_req;
   logic [1:0]         w_pick;
   logic               w_sel_valid;
   logic               w_sel_last;
   logic [WIDTH-1:0]   w_sel_data;
   logic               w_done;

   // Scan last+1, last+2, ... and take the first requester; iterating from the
   // farthest offset down lets the nearest one overwrite the pick.
   always_comb begin
      int idx;
      idx       = 0;
      w_any_req = 1'b0;
      w_pick    = 2'd0;
      for (int k = INPUTS; k >= 1; k--) begin
         idx = int'(r_last) + k;
         if (idx >= INPUTS) begin
            idx = idx - INPUTS;
         end
         for (int i = 0; i < INPUTS; i++) begin
            if ((i == idx) && s_tvalid[i]) begin
               w_any_req = 1'b1;
               w_pick    = 2'(i);
            end
         end
      end
   end

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      for (int i = 0; i < INPUTS; i++) begin
         if (r_grant == 2'(i)) begin
            w_sel_valid = s_tvalid[i];
            w_sel_last  = s_tlast[i];
            w_sel_data  = s_tdata[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_grant <= 2'd0;
         r_last  <= 2'(INPUTS-1);
      end else begin
         r_state <= w_state_next;
         r_grant <= w_grant_next;
         r_last  <= w_last_next;
      end
   end

   // The output side is a pure pass-through of the granted source while BUSY.
   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_last_next  = r_last;
      w_done       = 1'b0;
      m_tvalid     = 1'b0;
      m_tlast      = 1'b0;
      m_tdata      = '0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_grant_next = w_pick;
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            m_tvalid = w_sel_valid;
            m_tlast  = w_sel_last;
            m_tdata  = w_sel_data;
            if (w_sel_valid && m_tready && w_sel_last) begin
               w_done       = 1'b1;
               w_last_next  = r_grant;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   generate
      for (genvar gi = 0; gi < INPUTS; gi++) begin : g_src
         logic [CBITS-1:0] r_count;

         assign s_tready[gi] = (r_state == BUSY) && (r_grant == 2'(gi)) && m_tready;

         always_ff @(posedge clock) begin
            if (reset) begin
               r_count <= '0;
            end else if (w_done && (r_grant == 2'(gi))) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign count_o[gi*CBITS +: CBITS] = r_count;
      end
   endgenerate

   assign busy_o  = (r_state == BUSY);
   assign grant_o = r_grant;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter (3 sources, 2-bit counters) with a
// per-cycle reference model plus literal expectations per scenario.
module tb_packet_arbiter;
   localparam int W  = 8;
   localparam int N  = 3;
   localparam int CB = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    s_tvalid = '0;
   logic [N-1:0]    s_tready;
   logic [N-1:0]    s_tlast = '0;
   logic [N*W-1:0]  s_tdata = '0;
   logic            m_tvalid;
   logic            m_tready = 1'b1;
   logic            m_tlast;
   logic [W-1:0]    m_tdata;
   logic            busy_o;
   logic [1:0]      grant_o;
   logic [N*CB-1:0] count_o;

   packet_arbiter #(.WIDTH(W), .INPUTS(N), .CBITS(CB)) dut (
      .clock(clock), .reset(reset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
      .busy_o(busy_o), .grant_o(grant_o), .count_o(count_o)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;
   bit en      = 1'b0;

   logic [8:0]   q0[$];
   logic [8:0]   q1[$];
   logic [8:0]   q2[$];
   logic [N-1:0] paused = '0;
   logic [N-1:0] hs     = '0;

   // Reference state: busy flag, granted source, priority pointer, packet counts.
   bit mb = 1'b0;
   int mg = 0;
   int ml = N-1;
   int mc[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input int src, input logic last, input logic [7:0] data);
      case (src)
         0: q0.push_back({last, data});
         1: q1.push_back({last, data});
         default: q2.push_back({last, data});
      endcase
   endtask

   function automatic int qsize(input int src);
      case (src)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [8:0] qhead(input int src);
      case (src)
         0: return q0[0];
         1: return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpop(input int src);
      logic [8:0] tmp;
      case (src)
         0: tmp = q0.pop_front();
         1: tmp = q1.pop_front();
         default: tmp = q2.pop_front();
      endcase
   endtask

   function automatic int cnt(input int src);
      return int'(count_o[src*CB +: CB]);
   endfunction

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   // Handshakes are sampled mid-cycle while inputs and outputs are stable.
   initial forever begin
      @(negedge clock);
      hs = s_tvalid & s_tready;
   end

   // Source emulation: pop on handshake, otherwise hold the current beat.
   initial forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         logic [8:0] beat;
         if (hs[i] && qsize(i) > 0) qpop(i);
         if (qsize(i) > 0 && !paused[i]) begin
            beat = qhead(i);
            s_tvalid[i] = 1'b1;
            s_tlast[i]  = beat[8];
            s_tdata[i*W +: W] = beat[7:0];
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            s_tdata[i*W +: W] = '0;
         end
      end
   end

   // Per-cycle compare against the reference, then advance the reference.
   initial forever begin
      logic [N-1:0]    er;
      logic            ev;
      logic [N*CB-1:0] ec;
      @(negedge clock);
      if (en) begin
         ev = mb && s_tvalid[mg];
         for (int i = 0; i < N; i++) begin
            er[i] = mb && (i == mg) && m_tready;
            ec[i*CB +: CB] = CB'(mc[i]);
         end
         chk("busy", 32'(busy_o), 32'(mb));
         chk("grant", 32'(grant_o), 32'(mg));
         chk("count", 32'(count_o), 32'(ec));
         chk("s_tready", 32'(s_tready), 32'(er));
         chk("m_tvalid", 32'(m_tvalid), 32'(ev));
         if (ev) begin
            chk("m_tdata", 32'(m_tdata), 32'(s_tdata[mg*W +: W]));
            chk("m_tlast", 32'(m_tlast), 32'(s_tlast[mg]));
         end
      end
      if (reset) begin
         mb = 1'b0; mg = 0; ml = N-1;
         for (int i = 0; i < N; i++) mc[i] = 0;
      end else if (!mb) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ml + k) % N;
            if (!mb && s_tvalid[idx]) begin
               mg = idx;
               mb = 1'b1;
            end
         end
      end else if (s_tvalid[mg] && m_tready && s_tlast[mg]) begin
         mc[mg] = (mc[mg] + 1) % (1 << CB);
         ml = mg;
         mb = 1'b0;
         $display("packet done: src=%0d count=%0d", mg, mc[mg]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp2 [6];
      int         ord2 [6];
      int         exp6 [5];
      exp2 = '{8'h01, 8'h11, 8'h21, 8'h02, 8'h12, 8'h22};
      ord2 = '{0, 1, 2, 0, 1, 2};
      exp6 = '{1, 2, 3, 0, 1};

      reset = 1'b1;
      step();
      step();
      en = 1'b1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_tready", 32'(s_tready), 32'd0);
      chk("rst_mvalid", 32'(m_tvalid), 32'd0);

      // 3-beat packet from source 0
      reset = 1'b0;
      push(0, 1'b0, 8'h11); push(0, 1'b0, 8'h12); push(0, 1'b1, 8'h13);
      step(); chk("t1_arb_busy", 32'(busy_o), 32'd0);
      step(); chk("t1_busy", 32'(busy_o), 32'd1); chk("t1_grant", 32'(grant_o), 32'd0);
      chk("t1_d0", 32'(m_tdata), 32'h11);
      step(); chk("t1_d1", 32'(m_tdata), 32'h12);
      step(); chk("t1_d2", 32'(m_tdata), 32'h13); chk("t1_last", 32'(m_tlast), 32'd1);
      step(); chk("t1_done", 32'(busy_o), 32'd0); chk("t1_cnt0", 32'(cnt(0)), 32'd1);
      $display("txn: t1 3-beat packet src0");

      // all sources offering 1-beat packets: rotation 0,1,2,0,1,2
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int s = 0; s < N; s++) push(s, 1'b1, 8'(s*16 + k + 1));
      step();
      for (int j = 0; j < 6; j++) begin
         step();
         chk("t2_grant", 32'(grant_o), 32'(ord2[j]));
         chk("t2_data", 32'(m_tdata), 32'(exp2[j]));
         step();
         chk("t2_gap", 32'(busy_o), 32'd0);
         $display("txn: t2 packet %0d granted src=%0d", j, grant_o);
      end
      chk("t2_counts", 32'(count_o), 32'(6'b10_10_10));

      // 4-beat packet from source 1 with a 3-cycle sink stall on beat 2
      push(1, 1'b0, 8'h41); push(1, 1'b0, 8'h42); push(1, 1'b0, 8'h43); push(1, 1'b1, 8'h44);
      step(); chk("t3_idle", 32'(busy_o), 32'd0);
      step(); chk("t3_grant", 32'(grant_o), 32'd1); chk("t3_d0", 32'(m_tdata), 32'h41);
      step(); chk("t3_d1", 32'(m_tdata), 32'h42);
      m_tready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("t3_stall_data", 32'(m_tdata), 32'h42);
         chk("t3_stall_ready", 32'(s_tready), 32'd0);
         chk("t3_stall_valid", 32'(m_tvalid), 32'd1);
      end
      m_tready = 1'b1;
      step(); chk("t3_d2", 32'(m_tdata), 32'h43);
      step(); chk("t3_d3", 32'(m_tdata), 32'h44); chk("t3_last", 32'(m_tlast), 32'd1);
      step(); chk("t3_done", 32'(busy_o), 32'd0); chk("t3_cnt1", 32'(cnt(1)), 32'd3);
      $display("txn: t3 stalled 4-beat packet src1");

      // source 0 starves mid-packet while source 1 waits
      push(0, 1'b0, 8'h51); push(0, 1'b0, 8'h52); push(0, 1'b1, 8'h53);
      push(1, 1'b1, 8'h61);
      step(); chk("t4_idle", 32'(busy_o), 32'd0);
      step(); chk("t4_grant", 32'(grant_o), 32'd0); chk("t4_d0", 32'(m_tdata), 32'h51);
      paused[0] = 1'b1;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("t4_gap_valid", 32'(m_tvalid), 32'd0);
         chk("t4_gap_grant", 32'(grant_o), 32'd0);
         chk("t4_gap_busy", 32'(busy_o), 32'd1);
         chk("t4_gap_rdy1", 32'(s_tready[1]), 32'd0);
      end
      paused[0] = 1'b0;
      step(); chk("t4_d1", 32'(m_tdata), 32'h52); chk("t4_grant_hold", 32'(grant_o), 32'd0);
      step(); chk("t4_d2", 32'(m_tdata), 32'h53);
      step(); chk("t4_done", 32'(busy_o), 32'd0); chk("t4_cnt0", 32'(cnt(0)), 32'd3);
      step(); chk("t4_grant1", 32'(grant_o), 32'd1); chk("t4_d61", 32'(m_tdata), 32'h61);
      step(); chk("t4_done1", 32'(busy_o), 32'd0); chk("t4_cnt1_wrap", 32'(cnt(1)), 32'd0);
      $display("txn: t4 starved packet src0 then src1");

      // reset on beat 2 of a 4-beat packet
      push(0, 1'b0, 8'h71); push(0, 1'b0, 8'h72); push(0, 1'b0, 8'h73); push(0, 1'b1, 8'h74);
      step(); chk("t5_idle", 32'(busy_o), 32'd0);
      step(); chk("t5_grant", 32'(grant_o), 32'd0); chk("t5_d0", 32'(m_tdata), 32'h71);
      step(); chk("t5_d1", 32'(m_tdata), 32'h72);
      reset = 1'b1;
      q0.delete(); q1.delete(); q2.delete();
      step();
      chk("t5_busy", 32'(busy_o), 32'd0);
      chk("t5_grant_rst", 32'(grant_o), 32'd0);
      chk("t5_count", 32'(count_o), 32'd0);
      chk("t5_tready", 32'(s_tready), 32'd0);
      reset = 1'b0;
      push(0, 1'b1, 8'h81); push(1, 1'b1, 8'h91);
      step();
      step(); chk("t5_first", 32'(grant_o), 32'd0); chk("t5_d81", 32'(m_tdata), 32'h81);
      step(); chk("t5_gap", 32'(busy_o), 32'd0);
      step(); chk("t5_second", 32'(grant_o), 32'd1); chk("t5_d91", 32'(m_tdata), 32'h91);
      step(); chk("t5_counts", 32'(count_o), 32'(6'b00_01_01));
      $display("txn: t5 reset mid-packet then src0,src1");

      // 2-bit counter wrap on source 0
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) push(0, 1'b1, 8'(8'hA1 + k));
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t6_busy", 32'(busy_o), 32'd1);
         chk("t6_data", 32'(m_tdata), 32'(8'hA1 + k));
         step();
         chk("t6_cnt0", 32'(cnt(0)), 32'(exp6[k]));
         $display("txn: t6 packet %0d count0=%0d", k, cnt(0));
      end

      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
